// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory arbiter and the
//                debug unit: default geometry, starvation bound, byte-to-word
//                address conversion and access error check.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Default word-address width (memory depth is 2**ADDR_W_DEFAULT words)
    localparam int ADDR_W_DEFAULT     = 8;
    // Default number of consecutive denied DBG cycles before DBG is forced
    localparam int STARVE_MAX_DEFAULT = 4;

    // Word index of a byte address, masked to the memory depth.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                                 input int unsigned addr_w);
        logic [31:0] mask;
        mask = (32'h1 << addr_w) - 32'h1;
        return (byte_addr >> 2) & mask;
    endfunction

    // An access is illegal if it is not word-aligned or if it falls beyond
    // the end of the memory.
    function automatic logic addr_err(input logic [31:0] byte_addr,
                                      input int unsigned addr_w);
        logic misaligned;
        logic out_of_range;
        misaligned   = (byte_addr[1:0] != 2'b00);
        out_of_range = ((byte_addr >> (addr_w + 2)) != 32'h0);
        return misaligned | out_of_range;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_resp_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp_reg
//  Description : Response register for one arbiter port. Captures the result
//                of a granted access and presents it for exactly one cycle
//                (rvalid); rdata and err hold until the next grant.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                gnt             - access granted to this port this cycle
//                we              - granted access is a write
//                acc_err         - granted access is illegal
//                mem_spo         - memory asynchronous read data
//                rvalid          - one-cycle response pulse
//                rdata           - read data (0 for writes and errors)
//                err             - error flag for the response
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gnt,
    input  logic        we,
    input  logic        acc_err,
    input  logic [31:0] mem_spo,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= gnt;
            if (gnt) begin
                r_err   <= acc_err;
                // Writes and rejected accesses return zero data.
                r_rdata <= (!we && !acc_err) ? mem_spo : 32'h0;
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign err    = r_err;

endmodule : dmem_resp_reg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter sharing one single-port data memory between
//                the CPU MEM stage and the debug unit. CPU has priority; a
//                starvation counter forces a DBG grant after STARVE_MAX
//                consecutive denied DBG cycles. At most one access per cycle.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                cpu_* / dbg_* req,we,addr,wdata - request side per port
//                cpu_* / dbg_* gnt           - combinational grant
//                cpu_* / dbg_* rvalid,rdata,err - registered response
//                mem_a, mem_d, mem_we        - memory address/data/write enable
//                mem_spo                     - memory asynchronous read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,

    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_d,
    output logic              mem_we,
    input  logic [31:0]       mem_spo
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]        r_starve_cnt;
    logic              w_force_dbg;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic              w_any_gnt;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_we;
    logic              w_sel_err;
    logic [ADDR_W-1:0] w_sel_word;

    // ------------------------------------------------------------------
    // Grant logic. rst_n is folded in so nothing is granted (and nothing
    // is written) while reset is asserted, even with requests pending.
    // ------------------------------------------------------------------
    assign w_force_dbg = (r_starve_cnt == C_STARVE_MAX);
    assign w_cpu_gnt   = rst_n & cpu_req & ~w_force_dbg;
    assign w_dbg_gnt   = rst_n & dbg_req & (~cpu_req | w_force_dbg);
    assign w_any_gnt   = w_cpu_gnt | w_dbg_gnt;

    assign cpu_gnt = w_cpu_gnt;
    assign dbg_gnt = w_dbg_gnt;

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles in which DBG asks and
    // is refused. A forced grant clears it, so the CPU loses exactly one
    // cycle per starvation window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'h0;
        end else if (w_dbg_gnt || !dbg_req) begin
            r_starve_cnt <= 4'h0;
        end else if (r_starve_cnt != C_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'h1;
        end
    end

    // ------------------------------------------------------------------
    // Memory source mux. The DBG side is the default leg; the outputs are
    // gated to zero when nobody is granted.
    // ------------------------------------------------------------------
    assign w_sel_addr  = w_cpu_gnt ? cpu_addr  : dbg_addr;
    assign w_sel_wdata = w_cpu_gnt ? cpu_wdata : dbg_wdata;
    assign w_sel_we    = w_cpu_gnt ? cpu_we    : dbg_we;
    assign w_sel_err   = addr_err(w_sel_addr, ADDR_W);
    assign w_sel_word  = ADDR_W'(byte_to_word(w_sel_addr, ADDR_W));

    assign mem_a  = w_any_gnt ? w_sel_word  : '0;
    assign mem_d  = w_any_gnt ? w_sel_wdata : 32'h0;
    assign mem_we = w_any_gnt & w_sel_we & ~w_sel_err;

    // ------------------------------------------------------------------
    // Per-port response registers. Both see the shared we/err of the
    // selected access; only the granted one captures it.
    // ------------------------------------------------------------------
    dmem_resp_reg u_cpu_resp (
        .clk     (clk),
        .rst_n   (rst_n),
        .gnt     (w_cpu_gnt),
        .we      (w_sel_we),
        .acc_err (w_sel_err),
        .mem_spo (mem_spo),
        .rvalid  (cpu_rvalid),
        .rdata   (cpu_rdata),
        .err     (cpu_err)
    );

    dmem_resp_reg u_dbg_resp (
        .clk     (clk),
        .rst_n   (rst_n),
        .gnt     (w_dbg_gnt),
        .we      (w_sel_we),
        .acc_err (w_sel_err),
        .mem_spo (mem_spo),
        .rvalid  (dbg_rvalid),
        .rdata   (dbg_rdata),
        .err     (dbg_err)
    );

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Directed accesses push
//                their expected responses into per-port queues; a monitor
//                pops and compares on every rvalid. A behavioural 256-word
//                memory sits on the mem_* port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic [7:0]  mem_a;
    logic [31:0] mem_d, mem_spo;
    logic        mem_we;

    // bench-side memory with a preload port
    logic [31:0] tb_mem [256];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    resp_t cpu_q[$];
    resp_t dbg_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en)      tb_mem[pre_addr] <= pre_data;
        else if (mem_we) tb_mem[mem_a]    <= mem_d;
    end
    assign mem_spo = tb_mem[mem_a];

    dmem_arbiter #(.ADDR_W(8), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit is_dbg, input logic [31:0] rd, input logic e);
        resp_t r;
        r.rdata = rd;
        r.err   = e;
        if (is_dbg) dbg_q.push_back(r);
        else        cpu_q.push_back(r);
    endtask

    // Monitor: compare every response against the head of its queue.
    always @(negedge clk) begin
        resp_t r;
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                check("cpu_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                r = cpu_q.pop_front();
                check("cpu_rdata", cpu_rdata, r.rdata);
                check("cpu_err", {31'h0, cpu_err}, {31'h0, r.err});
            end
        end
        if (dbg_rvalid) begin
            if (dbg_q.size() == 0) begin
                check("dbg_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                r = dbg_q.pop_front();
                check("dbg_rdata", dbg_rdata, r.rdata);
                check("dbg_err", {31'h0, dbg_err}, {31'h0, r.err});
            end
        end
    end

    // Single access on one port. Called at posedge+1; returns at posedge+1
    // with the request dropped so the next access can follow back-to-back.
    task automatic do_access(input bit is_dbg, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input logic exp_err, input int exp_wait,
                             input logic exp_mem_we, input logic [7:0] exp_mem_a,
                             input string name);
        int   waited;
        logic g;
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        waited = 0;
        forever begin
            #3;
            g = is_dbg ? dbg_gnt : cpu_gnt;
            if (g) break;
            waited++;
            if (waited > 20) begin
                check({name, "_gnt_timeout"}, 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        if (g) begin
            check({name, "_wait"}, waited, exp_wait);
            check({name, "_mem_a"}, {24'h0, mem_a}, {24'h0, exp_mem_a});
            check({name, "_mem_we"}, {31'h0, mem_we}, {31'h0, exp_mem_we});
            if (exp_mem_we) check({name, "_mem_d"}, mem_d, wdata);
            push_exp(is_dbg, exp_rdata, exp_err);
        end
        @(posedge clk); #1;
        if (is_dbg) dbg_req = 1'b0;
        else        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pa [7];
        logic [31:0] pd [7];
        logic        ec, ed;
        pa = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd255};
        pd = '{32'h0BADF00D, 32'h22222222, 32'h12345678, 32'h44444444,
               32'h55555555, 32'h66666666, 32'h00000000};

        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0C; cpu_wdata = 32'hFFFFFFFF;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h08; dbg_wdata = 32'hFFFFFFFF;
        pre_en = 1'b0; pre_addr = 8'h0; pre_data = 32'h0;

        // preload memory while in reset (requests held high to test gating)
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            pre_en = 1'b1; pre_addr = pa[i]; pre_data = pd[i];
        end
        @(posedge clk); #1;
        pre_en = 1'b0;
        #3;
        check("rst_cpu_gnt", {31'h0, cpu_gnt}, 32'd0);
        check("rst_dbg_gnt", {31'h0, dbg_gnt}, 32'd0);
        check("rst_mem_we", {31'h0, mem_we}, 32'd0);
        check("rst_cpu_rvalid", {31'h0, cpu_rvalid}, 32'd0);
        check("rst_dbg_rvalid", {31'h0, dbg_rvalid}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0; dbg_req = 1'b0;

        // first grant in the first cycle after release
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_access(0, 0, 32'h0C, 32'h0, 32'h12345678, 0, 0, 0, 8'd3, "cpu_rd3");

        // DBG write then read of the last word
        do_access(1, 1, 32'h3FC, 32'hDEADBEEF, 32'h0, 0, 0, 1, 8'd255, "dbg_wr255");
        do_access(1, 0, 32'h3FC, 32'h0, 32'hDEADBEEF, 0, 0, 0, 8'd255, "dbg_rd255");

        // errors: misaligned write, out-of-range read, then word 0 intact
        do_access(0, 1, 32'h402, 32'hAAAA5555, 32'h0, 1, 0, 0, 8'd0, "cpu_wr_err");
        do_access(0, 0, 32'h400, 32'h0, 32'h0, 1, 0, 0, 8'd0, "cpu_rd_err");
        do_access(0, 0, 32'h000, 32'h0, 32'h0BADF00D, 0, 0, 0, 8'd0, "cpu_rd0");

        // starvation: CPU streams reads, DBG forced in cycles 4 and 9
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h14;
        for (int c = 0; c < 10; c++) begin
            #3;
            ec = (c != 4) && (c != 9);
            ed = !ec;
            check("starve_cpu_gnt", {31'h0, cpu_gnt}, {31'h0, ec});
            check("starve_dbg_gnt", {31'h0, dbg_gnt}, {31'h0, ed});
            if (ec) push_exp(0, 32'h44444444, 0);
            if (ed) push_exp(1, (c == 4) ? 32'h55555555 : 32'h66666666, 0);
            @(posedge clk); #1;
            if (c == 4) dbg_addr = 32'h18;
            if (c == 9) begin cpu_req = 1'b0; dbg_req = 1'b0; end
        end

        // simultaneous requests without starvation
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0C;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h18;
        #3;
        check("simul_cpu_gnt0", {31'h0, cpu_gnt}, 32'd1);
        check("simul_dbg_gnt0", {31'h0, dbg_gnt}, 32'd0);
        push_exp(0, 32'h12345678, 0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        #3;
        check("simul_cpu_gnt1", {31'h0, cpu_gnt}, 32'd0);
        check("simul_dbg_gnt1", {31'h0, dbg_gnt}, 32'd1);
        push_exp(1, 32'h66666666, 0);
        @(posedge clk); #1;
        dbg_req = 1'b0;

        // reset during a granted DBG write, before the edge
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h08; dbg_wdata = 32'hCAFEF00D;
        #2;
        check("rstmid_dbg_gnt_pre", {31'h0, dbg_gnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_dbg_gnt", {31'h0, dbg_gnt}, 32'd0);
        check("rstmid_mem_we", {31'h0, mem_we}, 32'd0);
        check("rstmid_cpu_rdata", cpu_rdata, 32'd0);
        check("rstmid_dbg_rdata", dbg_rdata, 32'd0);
        check("rstmid_rvalid", {30'h0, cpu_rvalid, dbg_rvalid}, 32'd0);
        check("rstmid_err", {30'h0, cpu_err, dbg_err}, 32'd0);
        @(posedge clk); #1;
        dbg_req = 1'b0; dbg_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_access(1, 0, 32'h08, 32'h0, 32'h22222222, 0, 0, 0, 8'd2, "post_rst_dbg_rd2");
        do_access(0, 0, 32'h0C, 32'h0, 32'h12345678, 0, 0, 0, 8'd3, "post_rst_cpu_rd3");

        repeat (3) @(posedge clk);
        #1;
        check("cpu_q_drained", cpu_q.size(), 32'd0);
        check("dbg_q_drained", dbg_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single 256-word data memory between the pipeline MEM stage (CPU port) and the debug unit (DBG port). It grants at most one access per cycle, drives the memory's word address, write data and write enable, and returns registered read data with a one-cycle response pulse. It sits between the MEM stage/debug unit and the memory instance. CPU has priority, bounded by a starvation counter that guarantees DBG progress.

## Interface
- ADDR_W, 8: word-address width (memory depth 2^ADDR_W words)
- STARVE_MAX, 4: consecutive denied DBG cycles before DBG is forced through (1..15)
- clk  in  1  system clock; memory writes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req / dbg_req  in  1  access request; held with addr/we/wdata stable until gnt
- cpu_we / dbg_we  in  1  1 = write, 0 = read
- cpu_addr / dbg_addr  in  32  byte address
- cpu_wdata / dbg_wdata  in  32  write data
- cpu_gnt / dbg_gnt  out  1  combinational grant, access performed this cycle
- cpu_rvalid / dbg_rvalid  out  1  registered one-cycle response pulse
- cpu_rdata / dbg_rdata  out  32  registered read data, valid with rvalid
- cpu_err / dbg_err  out  1  registered error flag, valid with rvalid
- mem_a  out  ADDR_W  word address to memory
- mem_d  out  32  write data to memory
- mem_we  out  1  memory write enable
- mem_spo  in  32  memory asynchronous read data

## Operation
- force_dbg = (starve_cnt == STARVE_MAX).
- cpu_gnt = rst_n & cpu_req & ~force_dbg; dbg_gnt = rst_n & dbg_req & (~cpu_req | force_dbg). Never both high.
- CPU stalls its pipeline while cpu_req & ~cpu_gnt.
- starve_cnt (4 bit): +1 when dbg_req & ~dbg_gnt, saturating at STARVE_MAX; cleared to 0 when dbg_gnt or ~dbg_req.
- Granted port selected as source: mem_a = addr[ADDR_W+1:2]; mem_d = wdata.
- err = (addr[1:0] != 0) | (addr[31:ADDR_W+2] != 0).
- mem_we = granted & we & ~err; no grant -> mem_we = 0, mem_a = 0, mem_d = 0.
- Response (registered, per port): on grant, rvalid <= 1, err <= err, rdata <= (~we & ~err) ? mem_spo : 0; otherwise rvalid <= 0, rdata and err hold.
- Writes are acknowledged with rvalid and rdata = 0.

## Timing
- Grant and memory access in cycle N (write commits at edge ending N); rvalid/rdata/err in cycle N+1.
- Read in N+1 observes a write committed in N (memory read is combinational).
- Back-to-back grants to the same port every cycle: rvalid high continuously.
- Reset (asynchronous, any time): rvalid, rdata, err = 0 on both ports; starve_cnt = 0; gnt and mem_we forced 0 while rst_n low. An access in flight at reset is dropped with no response.
- First grant possible in the first cycle after rst_n deasserts.
- Simultaneous requests: CPU wins unless force_dbg; a forced DBG grant clears starve_cnt, so the CPU is denied for exactly that one cycle.

## Structure
- Shared package dmem_pkg: ADDR_W default, STARVE_MAX default, byte-to-word address function, error-check function (also used by the debug unit).
- One natural sub-module: dmem_resp_reg (rvalid/rdata/err register for one port), instantiated twice.
- Grant logic, starvation counter and memory mux stay in the top level.

## Test plan
- CPU read alone: memory word 3 = 0x12345678, cpu_addr = 0x0C -> cpu_gnt in same cycle, mem_a = 3, next cycle cpu_rvalid = 1, cpu_rdata = 0x12345678, cpu_err = 0.
- Write then read: DBG write 0xDEADBEEF to 0x3FC, then DBG read 0x3FC -> mem_we pulse with mem_a = 255, read returns 0xDEADBEEF.
- Starvation: cpu_req held high, dbg_req raised at cycle 0 with STARVE_MAX = 4 -> dbg_gnt first high in cycle 4, cpu_gnt low only in cycle 4, starve_cnt 0 in cycle 5.
- Errors: CPU write to 0x402 and read of 0x400 -> mem_we stays 0, memory unchanged, cpu_err = 1, cpu_rdata = 0 on each response.
- Simultaneous requests with no starvation: both request in one cycle -> CPU granted, DBG waits; DBG granted the cycle after cpu_req drops.
- Reset mid-access: assert rst_n low during a granted DBG write cycle, before the edge -> no write, all rvalid/rdata/err = 0; after release, accesses resume normally.
